// File: rtl/risc_pkg.sv
// Shared encodings for the 8-bit RISC core: ALU/controller opcodes and
// instruction-cycle phase numbers.
package risc_pkg;

    // Opcodes (ADD/AND/XOR/LDA share their encoding with the ALU; LDA = PASSB)
    localparam logic [2:0] HLT = 3'd0;
    localparam logic [2:0] SKZ = 3'd1;
    localparam logic [2:0] ADD = 3'd2;
    localparam logic [2:0] AND = 3'd3;
    localparam logic [2:0] XOR = 3'd4;
    localparam logic [2:0] LDA = 3'd5;
    localparam logic [2:0] STO = 3'd6;
    localparam logic [2:0] JMP = 3'd7;

    // Instruction-cycle phases
    localparam logic [2:0] INST_ADDR  = 3'd0;
    localparam logic [2:0] INST_FETCH = 3'd1;
    localparam logic [2:0] INST_LOAD  = 3'd2;
    localparam logic [2:0] IDLE       = 3'd3;
    localparam logic [2:0] OP_ADDR    = 3'd4;
    localparam logic [2:0] OP_FETCH   = 3'd5;
    localparam logic [2:0] ALU_OP     = 3'd6;
    localparam logic [2:0] STORE      = 3'd7;

    // Opcodes whose result is written back to the accumulator from memory data
    function automatic logic is_aluop(input logic [2:0] op);
        return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
    endfunction

endpackage

// File: rtl/risc_controller_if.sv
// Controller <-> datapath strobe bundle. The controller is the master: it
// receives opcode/zero and drives every datapath strobe plus the phase trace.
interface risc_controller_if;
    logic [2:0] opcode;
    logic       zero;
    logic       sel;
    logic       rd;
    logic       ld_ir;
    logic       inc_pc;
    logic       ld_pc;
    logic       ld_ac;
    logic       wr;
    logic       data_e;
    logic       halt;
    logic [2:0] phase;

    modport master (
        input  opcode, zero,
        output sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt, phase
    );

    modport slave (
        output opcode, zero,
        input  sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt, phase
    );
endinterface

// File: rtl/risc_controller.sv
// Instruction sequencer for the 8-bit RISC core. An 8-phase counter steps
// once per clock; all strobes are decoded combinationally from the phase,
// the opcode held in the IR, the ALU zero flag and the sticky halted flag.
//
// phase      | meaning
// -----------+-------------------------------------------------
// INST_ADDR  | PC drives the address mux
// INST_FETCH | read instruction from memory
// INST_LOAD  | load instruction register
// IDLE       | hold IR load, opcode settles
// OP_ADDR    | advance PC past the instruction; HLT sets halted
// OP_FETCH   | read operand (ALU ops); parking phase when halted
// ALU_OP     | SKZ skip / JMP load / STO drives data bus
// STORE      | accumulator load, memory write, JMP target
module risc_controller
    import risc_pkg::*;
#(
    parameter int PHASE_W = 3
) (
    input  logic               clk,
    input  logic               rst,
    risc_controller_if.master  bus
);

    logic [PHASE_W-1:0] phase_q, phase_d;
    logic               halted_q, halted_d;

    logic sel_c, rd_c, ld_ir_c, inc_pc_c, ld_pc_c, ld_ac_c, wr_c, data_e_c, halt_c;
    logic aluop;

    assign aluop = is_aluop(bus.opcode);

    // Next phase and halted flag; a halted core parks at OP_FETCH
    always_comb begin
        phase_d  = phase_q;
        halted_d = halted_q;
        if (!halted_q) begin
            phase_d = phase_q + 1'b1;
            if ((phase_q == OP_ADDR) && (bus.opcode == HLT)) begin
                halted_d = 1'b1;
            end
        end
    end

    // Phase counter and halted flag; reset wins over everything
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q  <= INST_ADDR;
            halted_q <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            halted_q <= halted_d;
        end
    end

    // Strobe decode from phase, opcode, zero and halted
    always_comb begin
        sel_c    = 1'b0;
        rd_c     = 1'b0;
        ld_ir_c  = 1'b0;
        inc_pc_c = 1'b0;
        ld_pc_c  = 1'b0;
        ld_ac_c  = 1'b0;
        wr_c     = 1'b0;
        data_e_c = 1'b0;
        halt_c   = 1'b0;
        if (halted_q) begin
            halt_c = 1'b1;
        end else begin
            case (phase_q)
                INST_ADDR: begin
                    sel_c = 1'b1;
                end
                INST_FETCH: begin
                    sel_c = 1'b1;
                    rd_c  = 1'b1;
                end
                INST_LOAD, IDLE: begin
                    sel_c   = 1'b1;
                    rd_c    = 1'b1;
                    ld_ir_c = 1'b1;
                end
                OP_ADDR: begin
                    inc_pc_c = 1'b1;
                end
                OP_FETCH: begin
                    rd_c = aluop;
                end
                ALU_OP: begin
                    rd_c     = aluop;
                    inc_pc_c = (bus.opcode == SKZ) && bus.zero;
                    ld_pc_c  = (bus.opcode == JMP);
                    data_e_c = (bus.opcode == STO);
                end
                STORE: begin
                    rd_c     = aluop;
                    ld_ac_c  = aluop;
                    inc_pc_c = (bus.opcode == JMP);
                    ld_pc_c  = (bus.opcode == JMP);
                    data_e_c = (bus.opcode == STO);
                    wr_c     = (bus.opcode == STO);
                end
                default: begin
                    sel_c = 1'b0;
                end
            endcase
        end
    end

    assign bus.sel    = sel_c;
    assign bus.rd     = rd_c;
    assign bus.ld_ir  = ld_ir_c;
    assign bus.inc_pc = inc_pc_c;
    assign bus.ld_pc  = ld_pc_c;
    assign bus.ld_ac  = ld_ac_c;
    assign bus.wr     = wr_c;
    assign bus.data_e = data_e_c;
    assign bus.halt   = halt_c;
    assign bus.phase  = phase_q;

endmodule

// File: tb/tb_risc_controller.sv
// Self-checking bench for risc_controller: a cycle model of the instruction
// cycle checked every cycle, directed instruction runs with literal per-phase
// expectations, then randomized instruction streams with random resets.
module tb_risc_controller;
    import risc_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    risc_controller_if bus ();

    risc_controller #(.PHASE_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Reference state: current phase number and halted flag
    int m_phase  = 0;
    bit m_halted = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_phase  <= 0;
            m_halted <= 1'b0;
        end else if (!m_halted) begin
            if (m_phase == 4 && bus.opcode == HLT) m_halted <= 1'b1;
            m_phase <= (m_phase + 1) % 8;
        end
    end

    // Expected strobes {sel,rd,ld_ir,inc_pc,ld_pc,ld_ac,wr,data_e,halt}
    function automatic logic [8:0] expect_out(int ph, int op, bit z, bit h);
        bit alu, s, r, li, ip, lp, la, w, de;
        if (h) return 9'b0_0000_0001;
        alu = (op >= 2 && op <= 5);
        s   = (ph <= 3);
        r   = (ph >= 1 && ph <= 3) || (ph >= 5 && alu);
        li  = (ph == 2 || ph == 3);
        ip  = (ph == 4) || (ph == 6 && op == 1 && z) || (ph == 7 && op == 7);
        lp  = (ph >= 6 && op == 7);
        la  = (ph == 7 && alu);
        w   = (ph == 7 && op == 6);
        de  = (ph >= 6 && op == 6);
        return {s, r, li, ip, lp, la, w, de, 1'b0};
    endfunction

    function automatic logic [8:0] act_out();
        return {bus.sel, bus.rd, bus.ld_ir, bus.inc_pc, bus.ld_pc,
                bus.ld_ac, bus.wr, bus.data_e, bus.halt};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_phase", {29'd0, bus.phase}, m_phase);
            check("cyc_strobes", {23'd0, act_out()},
                  {23'd0, expect_out(m_phase, int'(bus.opcode), bus.zero, m_halted)});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // Run one full instruction from phase 0, collecting per-phase strobe bits
    logic [7:0] v_rd, v_ldir, v_inc, v_ldpc, v_ldac, v_wr, v_de;
    task automatic run_instr(input logic [2:0] op, input logic z);
        bus.opcode = op;
        bus.zero   = z;
        v_rd = '0; v_ldir = '0; v_inc = '0; v_ldpc = '0; v_ldac = '0; v_wr = '0; v_de = '0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            v_rd[i]   = bus.rd;
            v_ldir[i] = bus.ld_ir;
            v_inc[i]  = bus.inc_pc;
            v_ldpc[i] = bus.ld_pc;
            v_ldac[i] = bus.ld_ac;
            v_wr[i]   = bus.wr;
            v_de[i]   = bus.data_e;
            step();
        end
    endtask

    initial begin
        bus.opcode = ADD;
        bus.zero   = 1'b0;
        do_reset();
        chk_en = 1'b1;

        @(negedge clk);
        check("rst_phase", {29'd0, bus.phase}, 0);
        check("rst_out", {23'd0, act_out()}, 32'h100);
        step();
        do_reset();

        run_instr(ADD, 1'b0);
        check("add_rd", v_rd, 8'hEE);
        check("add_ldir", v_ldir, 8'h0C);
        check("add_inc", v_inc, 8'h10);
        check("add_ldac", v_ldac, 8'h80);
        check("add_wr_de", {v_wr, v_de}, 16'h0000);
        @(negedge clk);
        check("add_wrap", {29'd0, bus.phase}, 0);
        step();
        do_reset();

        run_instr(STO, 1'b1);
        check("sto_de", v_de, 8'hC0);
        check("sto_wr", v_wr, 8'h80);
        check("sto_rd", v_rd, 8'h0E);
        check("sto_ldac", v_ldac, 8'h00);

        run_instr(JMP, 1'b0);
        check("jmp_ldpc", v_ldpc, 8'hC0);
        check("jmp_inc", v_inc, 8'h90);
        check("jmp_rd", v_rd, 8'h0E);

        run_instr(SKZ, 1'b1);
        check("skz1_inc", v_inc, 8'h50);
        run_instr(SKZ, 1'b0);
        check("skz0_inc", v_inc, 8'h10);

        // HLT: inc_pc in phase 4, then parked at phase 5
        bus.opcode = HLT;
        bus.zero   = 1'b1;
        v_inc = '0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            v_inc[i] = bus.inc_pc;
            step();
        end
        check("hlt_inc", v_inc, 8'h10);
        for (int i = 0; i < 12; i++) begin
            bus.opcode = 3'($urandom_range(0, 7));
            bus.zero   = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("hlt_park", {22'd0, bus.phase, act_out()}, {22'd0, 3'd5, 9'h001});
            step();
        end
        do_reset();
        @(negedge clk);
        check("hlt_clear", {20'd0, bus.phase, bus.sel, bus.halt}, {20'd0, 3'd0, 1'b1, 1'b0});
        step();

        // Reset while STO is in ALU_OP
        do_reset();
        bus.opcode = STO;
        for (int i = 0; i < 6; i++) step();
        @(negedge clk);
        check("mid_ph6", {29'd0, bus.phase}, 6);
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst", {28'd0, bus.phase, bus.wr, bus.data_e, bus.sel},
              {28'd0, 3'd0, 1'b0, 1'b0, 1'b1});
        step();

        // Randomized instruction streams, model checks every cycle
        begin
            int hold = 0;
            for (int c = 0; c < 3000; c++) begin
                if ((m_halted && hold > 5) || $urandom_range(0, 99) == 0) begin
                    rst  = 1'b1;
                    hold = 0;
                end else begin
                    rst = 1'b0;
                    if (m_halted) hold++;
                end
                if (m_phase == 0 && !m_halted) begin
                    if ($urandom_range(0, 9) == 0) bus.opcode = HLT;
                    else bus.opcode = 3'($urandom_range(1, 7));
                end
                bus.zero = 1'($urandom_range(0, 1));
                step();
            end
            rst = 1'b0;
        end

        step();
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
